qdec_bs_fetch: RTL

QDEC_BS_FETCH -- requirements
Module: qdec_bs_fetch

---
 rtl/qdec_bs_fetch.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/qdec_bs_fetch.sv
// ---------------------------------------------------------------------------
// qdec_bs_fetch
//
// Reads a bitstream out of a word-addressed RAM (32-bit words) and delivers
// it to the CABAC decoder one byte at a time, most significant byte first.
// A 2-entry word FIFO decouples the RAM read pipeline from the byte output.
//
// Ports
//   clk                 in   1   sole clock, rising edge
//   rst                 in   1   asynchronous active-high reset
//   start               in   1   pulse to begin a fetch (only honoured in IDLE)
//   abort               in   1   synchronous cancel of the current fetch
//   base_addr           in  16   word address of first word (sampled on start)
//   byte_len            in  20   number of bytes to deliver (sampled on start)
//   mem_re              out  1   RAM word read request
//   mem_raddr           out 16   RAM word read address
//   mem_rdata           in  32   RAM read data, valid one cycle after mem_re
//   bitstreamFetch      out  8   byte to the decoder
//   bitstreamFetch_vld  out  1   byte valid
//   bitstreamFetch_rdy  in   1   decoder accepts the byte
//   busy                out  1   fetch in progress
//   done                out  1   one-cycle pulse after the final byte
//   dbg_state_o         out  2   current FSM state (IDLE=0, FETCH=1, DONE=2)
//
// Byte handshake: a byte transfers on every rising edge where
// bitstreamFetch_vld && bitstreamFetch_rdy && !abort. Once vld is raised,
// vld and bitstreamFetch hold their values until that transfer happens;
// only abort or rst may withdraw a byte that has been offered.
// ---------------------------------------------------------------------------
module qdec_bs_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] base_addr,
    input  logic [19:0] byte_len,
    output logic        mem_re,
    output logic [15:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  bitstreamFetch,
    output logic        bitstreamFetch_vld,
    input  logic        bitstreamFetch_rdy,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // FSM and control registers
    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        zero_len_q, zero_len_d;

    // Address / length bookkeeping
    logic [15:0] raddr_q, raddr_d;
    logic [18:0] words_rem_q, words_rem_d;
    logic [19:0] bytes_rem_q, bytes_rem_d;
    logic [1:0]  byte_idx_q, byte_idx_d;

    // Word FIFO
    logic [31:0] fifo_mem_q [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        inflight_q, inflight_d;

    // Internal control
    logic        load;
    logic        flush;
    logic        push;
    logic        pop;
    logic        hs;
    logic        last_byte;
    logic [1:0]  fifo_level;
    logic [18:0] words_needed;
    logic [31:0] head_word;
    logic [7:0]  head_byte;

    // ceil(byte_len / 4), computed one bit wider so 20'hFFFFF does not wrap
    assign words_needed = 19'(({1'b0, byte_len} + 21'd3) >> 2);

    // Words already in the FIFO plus the one whose data is on mem_rdata now
    assign fifo_level = count_q + {1'b0, inflight_q};

    assign mem_re    = (state_q == S_FETCH) && (words_rem_q != '0) && (fifo_level < 2'd2);
    assign mem_raddr = raddr_q;

    assign bitstreamFetch_vld = (state_q == S_FETCH) && (count_q != 2'd0) && (bytes_rem_q != '0);

    assign head_word = fifo_mem_q[rd_ptr_q];

    always_comb begin : head_byte_sel
        head_byte = 8'h00;
        case (byte_idx_q)
            2'd0:    head_byte = head_word[31:24];
            2'd1:    head_byte = head_word[23:16];
            2'd2:    head_byte = head_word[15:8];
            default: head_byte = head_word[7:0];
        endcase
    end

    assign bitstreamFetch = bitstreamFetch_vld ? head_byte : 8'h00;

    // abort wins over a byte handshake in the same cycle
    assign hs        = bitstreamFetch_vld && bitstreamFetch_rdy && !abort;
    assign last_byte = (bytes_rem_q == 20'd1);
    // The head word retires after its 4th byte, or early if it holds the
    // final byte (the unused trailing bytes are simply dropped).
    assign pop       = hs && ((byte_idx_q == 2'd3) || last_byte);
    // Read data lands one cycle after mem_re; inflight_q is cleared on any
    // flush so stale data from an aborted fetch is never written.
    assign push      = inflight_q && (state_q == S_FETCH);

    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

    // -----------------------------------------------------------------------
    // FSM next state
    // -----------------------------------------------------------------------
    always_comb begin : fsm_next
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        zero_len_d = zero_len_q;
        load       = 1'b0;
        flush      = 1'b0;

        if (abort) begin
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            zero_len_d = 1'b0;
            flush      = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        load   = 1'b1;
                        busy_d = 1'b1;
                        if (byte_len == '0) begin
                            state_d    = S_DONE;
                            zero_len_d = 1'b1;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (hs && last_byte) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        flush   = 1'b1;
                    end
                end
                S_DONE: begin
                    // A normal fetch already pulsed done on entry. An empty
                    // fetch spends this cycle busy and pulses done on exit.
                    state_d    = S_IDLE;
                    zero_len_d = 1'b0;
                    if (zero_len_q) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Datapath next state
    // -----------------------------------------------------------------------
    always_comb begin : datapath_next
        raddr_d     = raddr_q;
        words_rem_d = words_rem_q;
        bytes_rem_d = bytes_rem_q;
        byte_idx_d  = byte_idx_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        inflight_d  = mem_re && !flush;

        if (flush) begin
            words_rem_d = '0;
            bytes_rem_d = '0;
            byte_idx_d  = '0;
            wr_ptr_d    = 1'b0;
            rd_ptr_d    = 1'b0;
            count_d     = '0;
        end else if (load) begin
            raddr_d     = base_addr;
            words_rem_d = words_needed;
            bytes_rem_d = byte_len;
            byte_idx_d  = '0;
        end else begin
            if (mem_re) begin
                raddr_d     = raddr_q + 16'd1;
                words_rem_d = words_rem_q - 19'd1;
            end
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (hs) begin
                bytes_rem_d = bytes_rem_q - 20'd1;
                byte_idx_d  = pop ? 2'd0 : (byte_idx_q + 2'd1);
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            zero_len_q  <= 1'b0;
            raddr_q     <= '0;
            words_rem_q <= '0;
            bytes_rem_q <= '0;
            byte_idx_q  <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            zero_len_q  <= zero_len_d;
            raddr_q     <= raddr_d;
            words_rem_q <= words_rem_d;
            bytes_rem_q <= bytes_rem_d;
            byte_idx_q  <= byte_idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else if (push && !flush) begin
            fifo_mem_q[wr_ptr_q] <= mem_rdata;
        end
    end

endmodule
